// File: rtl/lab7_sos_nios2_qsys_0_ocimem_arbiter.sv
// OCI RAM arbiter: sequences JTAG debug load/read/write with address auto-increment
// and round-robin shares the single-port RAM with the CPU debug-slave port.
module lab7_sos_nios2_qsys_0_ocimem_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_no_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  input  logic [37:0]           jdo,
  input  logic [ADDR_W-1:0]     cpu_address,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [DATA_W-1:0]     cpu_writedata,
  input  logic [DATA_W/8-1:0]   cpu_byteenable,
  output logic                  cpu_waitrequest,
  output logic [DATA_W-1:0]     cpu_readdata,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_wren,
  output logic [DATA_W-1:0]     ram_wdata,
  output logic [DATA_W/8-1:0]   ram_byteen,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic [DATA_W-1:0]     MonDReg,
  output logic                  monitor_ready,
  output logic                  monitor_error
);

  localparam int unsigned JADDR_LSB = 17;
  localparam int unsigned JDATA_LSB = 3;
  localparam int unsigned JRD_BIT   = 34;

  typedef enum logic [2:0] {
    IDLE,
    J_WR,
    J_RD,
    J_RD_DATA,
    C_WR,
    C_RD,
    C_RD_DATA
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   jaddr;
  logic                pend;
  logic                pend_wr;
  logic [DATA_W-1:0]   pend_data;
  logic                last_grant_jtag;

  logic                jtag_pulse;
  logic                cpu_req;
  logic                grant_jtag;
  logic                unused_jdo;

  assign jtag_pulse = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign cpu_req    = cpu_read | cpu_write;
  // Round-robin: on contention the requester not served last wins.
  assign grant_jtag = pend & (~cpu_req | ~last_grant_jtag);
  assign unused_jdo = ^jdo;

  // Read data is only meaningful while the RAM is returning the CPU's word.
  assign cpu_readdata = (state == C_RD_DATA) ? ram_rdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      jaddr           <= '0;
      pend            <= 1'b0;
      pend_wr         <= 1'b0;
      pend_data       <= '0;
      last_grant_jtag <= 1'b0;
      MonDReg         <= '0;
      monitor_ready   <= 1'b0;
      monitor_error   <= 1'b0;
      ram_wren        <= 1'b0;
      ram_addr        <= '0;
      ram_wdata       <= '0;
      ram_byteen      <= '0;
      cpu_waitrequest <= 1'b1;
    end else begin
      ram_wren        <= 1'b0;
      cpu_waitrequest <= 1'b1;

      // JTAG capture into the single pending slot; a pulse while busy is dropped.
      if (jtag_pulse) begin
        if (pend) begin
          monitor_error <= 1'b1;
        end else begin
          monitor_ready <= 1'b0;
          if (take_action_ocimem_a) begin
            monitor_error <= 1'b0;
            jaddr         <= jdo[JADDR_LSB +: ADDR_W];
            pend          <= jdo[JRD_BIT];
            pend_wr       <= 1'b0;
          end else if (take_action_ocimem_b) begin
            pend      <= 1'b1;
            pend_wr   <= 1'b1;
            pend_data <= jdo[JDATA_LSB +: DATA_W];
          end else begin
            pend    <= 1'b1;
            pend_wr <= 1'b0;
          end
        end
      end

      case (state)
        IDLE: begin
          if (grant_jtag) begin
            last_grant_jtag <= 1'b1;
            ram_addr        <= jaddr;
            ram_byteen      <= '1;
            if (pend_wr) begin
              state     <= J_WR;
              ram_wren  <= 1'b1;
              ram_wdata <= pend_data;
            end else begin
              state <= J_RD;
            end
          end else if (cpu_req) begin
            last_grant_jtag <= 1'b0;
            ram_addr        <= cpu_address;
            ram_byteen      <= cpu_byteenable;
            if (cpu_write) begin
              state           <= C_WR;
              ram_wren        <= 1'b1;
              ram_wdata       <= cpu_writedata;
              cpu_waitrequest <= 1'b0;
            end else begin
              state <= C_RD;
            end
          end
        end
        J_WR: begin
          jaddr <= jaddr + ADDR_W'(1);
          pend  <= 1'b0;
          state <= IDLE;
        end
        J_RD: begin
          state <= J_RD_DATA;
        end
        J_RD_DATA: begin
          MonDReg       <= ram_rdata;
          monitor_ready <= 1'b1;
          jaddr         <= jaddr + ADDR_W'(1);
          pend          <= 1'b0;
          state         <= IDLE;
        end
        C_WR: begin
          state <= IDLE;
        end
        C_RD: begin
          cpu_waitrequest <= 1'b0;
          state           <= C_RD_DATA;
        end
        C_RD_DATA: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lab7_sos_nios2_qsys_0_ocimem_arbiter.sv
// Scoreboard bench for the OCI RAM arbiter with a behavioural 1-cycle-latency RAM.
module tb_lab7_sos_nios2_qsys_0_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [37:0] jdo;
  logic [7:0]  cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic        cpu_waitrequest;
  logic [31:0] cpu_readdata;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_byteen;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_mon[$];
  logic [31:0] exp_cpu[$];
  logic [31:0] mem [256];

  always #5 clk = ~clk;

  lab7_sos_nios2_qsys_0_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .jdo                     (jdo),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_write               (cpu_write),
    .cpu_writedata           (cpu_writedata),
    .cpu_byteenable          (cpu_byteenable),
    .cpu_waitrequest         (cpu_waitrequest),
    .cpu_readdata            (cpu_readdata),
    .ram_addr                (ram_addr),
    .ram_wren                (ram_wren),
    .ram_wdata               (ram_wdata),
    .ram_byteen              (ram_byteen),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  function automatic logic [31:0] pat(input int i);
    return 32'hA5A50000 | 32'(i);
  endfunction

  // RAM model: byte-enabled write, registered read of the old word.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      ram_rdata <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (ram_wren && ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a(input logic [7:0] addr, input logic rd);
    jdo = '0;
    jdo[24:17] = addr;
    jdo[34] = rd;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    jdo = '0;
  endtask

  task automatic pulse_b(input logic [31:0] data);
    jdo = '0;
    jdo[34:3] = data;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    jdo = '0;
  endtask

  task automatic pulse_n();
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic wait_mon(input string name);
    int cyc;
    logic [31:0] e;
    cyc = 0;
    while (monitor_ready !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    n_cmp++;
    if (monitor_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_ready: monitor_ready=%b required 1 within 20 cycles", name, monitor_ready);
      void'(exp_mon.pop_front());
    end else begin
      e = exp_mon.pop_front();
      n_cmp++;
      if (MonDReg !== e) begin
        n_bad++;
        $display("FAIL %s_data: MonDReg=%h required %h", name, MonDReg, e);
      end
    end
  endtask

  // Issues one CPU transfer, returns cycles to completion, then idles the bus for a cycle.
  task automatic cpu_op(input logic rd, input logic wr, input logic [7:0] addr,
                        input logic [31:0] data, input logic [3:0] be,
                        output int cyc, output logic [31:0] rdata);
    cpu_read = rd;
    cpu_write = wr;
    cpu_address = addr;
    cpu_writedata = data;
    cpu_byteenable = be;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (cpu_waitrequest !== 1'b0 && cyc < 30);
    rdata = cpu_readdata;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_cmp++;
    if ({cpu_waitrequest, monitor_ready, monitor_error, ram_wren} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_flags: wait/ready/err/wren=%b required 1000",
               {cpu_waitrequest, monitor_ready, monitor_error, ram_wren});
    end
    n_cmp++;
    if ({ram_addr, ram_wdata, ram_byteen, MonDReg, cpu_readdata} !== 108'd0) begin
      n_bad++;
      $display("FAIL reset_data: addr=%h wdata=%h be=%h mon=%h rdata=%h required all 0",
               ram_addr, ram_wdata, ram_byteen, MonDReg, cpu_readdata);
    end
    reset_n = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (cpu_waitrequest !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_wait: cpu_waitrequest=%b required 1", cpu_waitrequest);
    end
  endtask

  task automatic test_write_seq();
    pulse_a(8'h10, 1'b0);
    pulse_b(32'hDEADBEEF);
    tick();
    n_cmp++;
    if ({ram_wren, ram_addr, ram_wdata, ram_byteen} !== {1'b1, 8'h10, 32'hDEADBEEF, 4'hF}) begin
      n_bad++;
      $display("FAIL jwr_port: wren=%b addr=%h wdata=%h be=%h required 1 10 deadbeef f",
               ram_wren, ram_addr, ram_wdata, ram_byteen);
    end
    repeat (2) tick();
    pulse_b(32'h12345678);
    repeat (3) tick();
    n_cmp++;
    if (mem[8'h10] !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL jwr_mem10: RAM[10]=%h required deadbeef", mem[8'h10]);
    end
    n_cmp++;
    if (mem[8'h11] !== 32'h12345678) begin
      n_bad++;
      $display("FAIL jwr_mem11: RAM[11]=%h required 12345678", mem[8'h11]);
    end
    // jaddr should now sit at 0x12.
    exp_mon.push_back(pat(8'h12));
    pulse_n();
    wait_mon("jaddr_after_writes");
    n_cmp++;
    if (monitor_error !== 1'b0) begin
      n_bad++;
      $display("FAIL jwr_err: monitor_error=%b required 0", monitor_error);
    end
  endtask

  task automatic test_read_load();
    tick();
    exp_mon.push_back(32'hDEADBEEF);
    pulse_a(8'h10, 1'b1);
    n_cmp++;
    if (monitor_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rdld_clear: monitor_ready=%b required 0 after pulse", monitor_ready);
    end
    repeat (2) tick();
    n_cmp++;
    if (monitor_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rdld_early: monitor_ready=%b required 0 at cycle 2", monitor_ready);
    end
    tick();
    n_cmp++;
    if (monitor_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rdld_latency: monitor_ready=%b required 1 at cycle 3", monitor_ready);
    end
    wait_mon("rdld");
    exp_mon.push_back(32'h12345678);
    pulse_n();
    wait_mon("rd_next");
  endtask

  task automatic test_wrap();
    tick();
    pulse_a(8'hFF, 1'b0);
    pulse_b(32'hCAFE0001);
    repeat (3) tick();
    pulse_b(32'hCAFE0002);
    repeat (3) tick();
    n_cmp++;
    if (mem[8'hFF] !== 32'hCAFE0001) begin
      n_bad++;
      $display("FAIL wrap_ff: RAM[ff]=%h required cafe0001", mem[8'hFF]);
    end
    n_cmp++;
    if (mem[8'h00] !== 32'hCAFE0002) begin
      n_bad++;
      $display("FAIL wrap_00: RAM[00]=%h required cafe0002", mem[8'h00]);
    end
  endtask

  task automatic test_cpu_basic();
    int cyc;
    logic [31:0] rd;
    logic [31:0] e;
    cpu_op(1'b0, 1'b1, 8'h05, 32'h11223344, 4'hF, cyc, rd);
    n_cmp++;
    if (cyc != 1) begin
      n_bad++;
      $display("FAIL cwr_latency: cycles=%0d required 1", cyc);
    end
    exp_cpu.push_back(32'h11223344);
    cpu_op(1'b1, 1'b0, 8'h05, 32'h0, 4'hF, cyc, rd);
    e = exp_cpu.pop_front();
    n_cmp++;
    if (cyc != 2) begin
      n_bad++;
      $display("FAIL crd_latency: cycles=%0d required 2", cyc);
    end
    n_cmp++;
    if (rd !== e) begin
      n_bad++;
      $display("FAIL crd_data: readdata=%h required %h", rd, e);
    end
    cpu_op(1'b0, 1'b1, 8'h05, 32'hAABBCCDD, 4'b0101, cyc, rd);
    n_cmp++;
    if (mem[8'h05] !== 32'h11BB33DD) begin
      n_bad++;
      $display("FAIL cwr_bytes: RAM[05]=%h required 11bb33dd", mem[8'h05]);
    end
    cpu_op(1'b1, 1'b1, 8'h06, 32'h0BADF00D, 4'hF, cyc, rd);
    n_cmp++;
    if (cyc != 1 || mem[8'h06] !== 32'h0BADF00D) begin
      n_bad++;
      $display("FAIL crw_both: cycles=%0d RAM[06]=%h required 1 0badf00d", cyc, mem[8'h06]);
    end
  endtask

  task automatic test_contention();
    pulse_a(8'h40, 1'b0);
    fork
      begin
        int cyc;
        logic [31:0] rd;
        logic [31:0] e;
        for (int i = 0; i < 10; i++) begin
          exp_cpu.push_back(pat(8'h20));
          cpu_op(1'b1, 1'b0, 8'h20, 32'h0, 4'hF, cyc, rd);
          e = exp_cpu.pop_front();
          n_cmp++;
          if (cyc > 4 || rd !== e) begin
            n_bad++;
            $display("FAIL cont_cpu%0d: cycles=%0d data=%h required <=4 %h", i, cyc, rd, e);
          end
        end
      end
      begin
        int c;
        for (int i = 0; i < 10; i++) begin
          pulse_b(32'h55 + 32'(i));
          c = 0;
          while (!(ram_wren === 1'b1 && ram_wdata === 32'h55 + 32'(i)) && c < 20) begin
            tick();
            c++;
          end
          n_cmp++;
          if (c >= 20) begin
            n_bad++;
            $display("FAIL cont_jtag%0d: write not granted in %0d cycles", i, c);
          end
          tick();
        end
      end
    join
    repeat (2) tick();
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (mem[8'h40 + 8'(i)] !== 32'h55 + 32'(i)) begin
        n_bad++;
        $display("FAIL cont_mem%0d: RAM=%h required %h", i, mem[8'h40 + 8'(i)], 32'h55 + 32'(i));
      end
    end
  endtask

  task automatic test_overrun();
    tick();
    pulse_a(8'h30, 1'b0);
    fork
      begin
        int cyc;
        logic [31:0] rd;
        logic [31:0] e;
        for (int i = 0; i < 3; i++) begin
          exp_cpu.push_back(pat(8'h20));
          cpu_op(1'b1, 1'b0, 8'h20, 32'h0, 4'hF, cyc, rd);
          e = exp_cpu.pop_front();
          n_cmp++;
          if (rd !== e) begin
            n_bad++;
            $display("FAIL ovr_cpu%0d: data=%h required %h", i, rd, e);
          end
        end
      end
      begin
        pulse_b(32'h1111AAAA);
        pulse_b(32'h2222BBBB);
        n_cmp++;
        if (monitor_error !== 1'b1) begin
          n_bad++;
          $display("FAIL ovr_set: monitor_error=%b required 1", monitor_error);
        end
      end
    join
    repeat (4) tick();
    n_cmp++;
    if (mem[8'h30] !== 32'h1111AAAA || mem[8'h31] !== pat(8'h31)) begin
      n_bad++;
      $display("FAIL ovr_mem: RAM[30]=%h RAM[31]=%h required 1111aaaa %h",
               mem[8'h30], mem[8'h31], pat(8'h31));
    end
    n_cmp++;
    if (monitor_error !== 1'b1) begin
      n_bad++;
      $display("FAIL ovr_sticky: monitor_error=%b required 1", monitor_error);
    end
    pulse_a(8'h00, 1'b0);
    n_cmp++;
    if (monitor_error !== 1'b0) begin
      n_bad++;
      $display("FAIL ovr_clear: monitor_error=%b required 0", monitor_error);
    end
  endtask

  task automatic test_reset_mid();
    exp_mon.push_back(32'hCAFE0002);
    pulse_n();
    wait_mon("pre_reset_rd");
    cpu_read = 1'b1;
    cpu_address = 8'h20;
    tick();
    n_cmp++;
    if (ram_addr !== 8'h20 || cpu_waitrequest !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_crd: addr=%h wait=%b required 20 1", ram_addr, cpu_waitrequest);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({cpu_waitrequest, monitor_ready, monitor_error, ram_wren} !== 4'b1000) begin
      n_bad++;
      $display("FAIL rst_mid_flags: wait/ready/err/wren=%b required 1000",
               {cpu_waitrequest, monitor_ready, monitor_error, ram_wren});
    end
    n_cmp++;
    if ({ram_addr, ram_wdata, ram_byteen, MonDReg, cpu_readdata} !== 108'd0) begin
      n_bad++;
      $display("FAIL rst_mid_data: addr=%h wdata=%h be=%h mon=%h rdata=%h required all 0",
               ram_addr, ram_wdata, ram_byteen, MonDReg, cpu_readdata);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (ram_wren !== 1'b0 || cpu_waitrequest !== 1'b1) begin
        n_bad++;
        $display("FAIL rst_hold%0d: wren=%b wait=%b required 0 1", i, ram_wren, cpu_waitrequest);
      end
    end
    cpu_read = 1'b0;
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    reset_n = 1'b0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    jdo = '0;
    cpu_address = '0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_writedata = '0;
    cpu_byteenable = '0;
    test_reset();
    test_write_seq();
    test_read_load();
    test_wrap();
    test_cpu_basic();
    test_contention();
    test_overrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
